// File: rtl/sum_block_accumulator_if.sv
// rtl/sum_block_accumulator_if.sv - sum input stream, clear and block-result handshake bundle
interface sum_block_accumulator_if #(
    parameter int IN_W  = 33,
    parameter int ACC_W = 40
);
    logic [IN_W-1:0]  sum_in;
    logic             in_valid;
    logic             in_ready;
    logic             clear;
    logic [ACC_W-1:0] acc_out;
    logic             acc_ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output sum_in, in_valid, clear, out_ready,
        input  in_ready, acc_out, acc_ovf, out_valid
    );

    modport slave (
        input  sum_in, in_valid, clear, out_ready,
        output in_ready, acc_out, acc_ovf, out_valid
    );
endinterface

// File: rtl/sum_block_accumulator.sv
// rtl/sum_block_accumulator.sv - accumulates COUNT adder sums per block, wrapping total with sticky overflow
module sum_block_accumulator #(
    parameter int IN_W  = 33,
    parameter int ACC_W = 40,
    parameter int COUNT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sum_block_accumulator_if.slave bus
);
    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             transfer;
    logic             last;
    logic [ACC_W:0]   sum_ext;

    // Handshakes decode from the state register only, so no input reaches an output combinationally.
    assign accept   = bus.in_valid  && (state == ACCUM);
    assign transfer = bus.out_ready && (state == HOLD);
    assign last     = (count == LAST_IDX);
    assign sum_ext  = {1'b0, acc} + (ACC_W + 1)'(bus.sum_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ACCUM;
            ACCUM:   if (accept && last) state_nxt = HOLD;
            HOLD:    if (transfer) state_nxt = ACCUM;
            default: state_nxt = IDLE;
        endcase
        if (bus.clear) begin
            state_nxt = ACCUM;
        end
    end

    always_comb begin
        bus.in_ready  = (state == ACCUM);
        bus.out_valid = (state == HOLD);
        bus.acc_out   = acc;
        bus.acc_ovf   = ovf;
    end

    // clear outranks both transfer and accept; the sum offered alongside it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (bus.clear || transfer) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (accept) begin
            acc   <= sum_ext[ACC_W-1:0];
            ovf   <= ovf | sum_ext[ACC_W];
            count <= last ? '0 : count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_sum_block_accumulator.sv
// tb/tb_sum_block_accumulator.sv - directed self-checking bench for sum_block_accumulator
module tb_sum_block_accumulator;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sum_block_accumulator_if #(.IN_W(33), .ACC_W(40)) b0 ();
    sum_block_accumulator_if #(.IN_W(33), .ACC_W(34)) b1 ();
    sum_block_accumulator_if #(.IN_W(33), .ACC_W(40)) b2 ();

    sum_block_accumulator #(.IN_W(33), .ACC_W(40), .COUNT(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    sum_block_accumulator #(.IN_W(33), .ACC_W(34), .COUNT(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    sum_block_accumulator #(.IN_W(33), .ACC_W(40), .COUNT(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [42:0] got;
    logic [42:0] exp;
    logic [1:0]  hs;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b0.sum_in = '0; b0.in_valid = 1'b0; b0.clear = 1'b0; b0.out_ready = 1'b0;
        b1.sum_in = '0; b1.in_valid = 1'b0; b1.clear = 1'b0; b1.out_ready = 1'b0;
        b2.sum_in = '0; b2.in_valid = 1'b0; b2.clear = 1'b0; b2.out_ready = 1'b0;
    endtask

    task automatic feed0(input logic [32:0] v);
        b0.sum_in   = v;
        b0.in_valid = 1'b1;
        step();
        b0.in_valid = 1'b0;
    endtask

    task automatic xfer0();
        b0.out_ready = 1'b1;
        step();
        b0.out_ready = 1'b0;
    endtask

    function automatic logic [42:0] pk(input logic ir, input logic ov, input logic of, input logic [39:0] a);
        return {ir, ov, of, a};
    endfunction

    function automatic logic [42:0] snap0();
        return {b0.in_ready, b0.out_valid, b0.acc_ovf, b0.acc_out};
    endfunction

    function automatic logic [42:0] snap1();
        return {b1.in_ready, b1.out_valid, b1.acc_ovf, 6'd0, b1.acc_out};
    endfunction

    function automatic logic [42:0] snap2();
        return {b2.in_ready, b2.out_valid, b2.acc_ovf, b2.acc_out};
    endfunction

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        step();
        step();
        got = snap0(); exp = pk(0, 0, 0, 40'd0); total_cnt++;
        if (got !== exp) $display("FAIL reset_b0 got=%h exp=%h", got, exp); else pass_cnt++;
        got = snap1(); total_cnt++;
        if (got !== exp) $display("FAIL reset_b1 got=%h exp=%h", got, exp); else pass_cnt++;
        got = snap2(); total_cnt++;
        if (got !== exp) $display("FAIL reset_b2 got=%h exp=%h", got, exp); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        hs = {b0.in_ready, b0.out_valid}; total_cnt++;
        if (hs !== 2'b00) $display("FAIL idle_before_edge got=%b exp=00", hs); else pass_cnt++;
        step();
        hs = {b0.in_ready, b0.out_valid}; total_cnt++;
        if (hs !== 2'b10) $display("FAIL accum_after_release got=%b exp=10", hs); else pass_cnt++;
    endtask

    task automatic test_basic();
        feed0(33'd1);
        feed0(33'd2);
        feed0(33'd3);
        hs = {b0.in_ready, b0.out_valid}; total_cnt++;
        if (hs !== 2'b10) $display("FAIL basic_mid_block got=%b exp=10", hs); else pass_cnt++;
        feed0(33'd4);
        got = snap0(); exp = pk(0, 1, 0, 40'd10); total_cnt++;
        if (got !== exp) $display("FAIL basic_result got=%h exp=%h", got, exp); else pass_cnt++;
        xfer0();
        hs = {b0.in_ready, b0.out_valid}; total_cnt++;
        if (hs !== 2'b10) $display("FAIL basic_after_xfer got=%b exp=10", hs); else pass_cnt++;
    endtask

    task automatic test_overflow();
        b0.sum_in = 33'h1_FFFF_FFFF; b0.in_valid = 1'b1;
        b1.sum_in = 33'h1_FFFF_FFFF; b1.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        b0.in_valid = 1'b0;
        b1.in_valid = 1'b0;
        got = snap0(); exp = pk(0, 1, 0, 40'h07_FFFF_FFFC); total_cnt++;
        if (got !== exp) $display("FAIL max_acc40 got=%h exp=%h", got, exp); else pass_cnt++;
        got = snap1(); exp = pk(0, 1, 1, 40'h03_FFFF_FFFC); total_cnt++;
        if (got !== exp) $display("FAIL ovf_acc34 got=%h exp=%h", got, exp); else pass_cnt++;
        b0.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        step();
        b0.out_ready = 1'b0;
        b1.out_ready = 1'b0;
        b1.sum_in = 33'd1; b1.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        b1.in_valid = 1'b0;
        got = snap1(); exp = pk(0, 1, 0, 40'd4); total_cnt++;
        if (got !== exp) $display("FAIL ovf_cleared_next_block got=%h exp=%h", got, exp); else pass_cnt++;
        b1.out_ready = 1'b1;
        step();
        b1.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic        vld [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [32:0] val [7] = '{33'd3, 33'd100, 33'd5, 33'd100, 33'd100, 33'd7, 33'd11};
        for (int i = 0; i < 7; i++) begin
            b0.sum_in   = val[i];
            b0.in_valid = vld[i];
            step();
        end
        b0.in_valid = 1'b0;
        got = snap0(); exp = pk(0, 1, 0, 40'd26); total_cnt++;
        if (got !== exp) $display("FAIL gaps_result got=%h exp=%h", got, exp); else pass_cnt++;
        b0.sum_in   = 33'd7;
        b0.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            got = snap0(); total_cnt++;
            if (got !== exp) $display("FAIL hold_stable_%0d got=%h exp=%h", i, got, exp); else pass_cnt++;
        end
        xfer0();
        hs = {b0.in_ready, b0.out_valid}; total_cnt++;
        if (hs !== 2'b10) $display("FAIL hold_release got=%b exp=10", hs); else pass_cnt++;
        step();
        b0.in_valid = 1'b0;
        feed0(33'd1);
        feed0(33'd1);
        feed0(33'd1);
        got = snap0(); exp = pk(0, 1, 0, 40'd10); total_cnt++;
        if (got !== exp) $display("FAIL held_seven_absorbed got=%h exp=%h", got, exp); else pass_cnt++;
        xfer0();
    endtask

    task automatic test_clear();
        feed0(33'd5);
        feed0(33'd6);
        b0.clear = 1'b1; b0.sum_in = 33'd9; b0.in_valid = 1'b1;
        step();
        b0.clear = 1'b0; b0.in_valid = 1'b0;
        hs = {b0.in_ready, b0.out_valid}; total_cnt++;
        if (hs !== 2'b10) $display("FAIL clear_accum_state got=%b exp=10", hs); else pass_cnt++;
        feed0(33'd1);
        feed0(33'd2);
        feed0(33'd3);
        feed0(33'd4);
        got = snap0(); exp = pk(0, 1, 0, 40'd10); total_cnt++;
        if (got !== exp) $display("FAIL clear_next_block got=%h exp=%h", got, exp); else pass_cnt++;
        b0.clear = 1'b1; b0.out_ready = 1'b1;
        step();
        b0.clear = 1'b0; b0.out_ready = 1'b0;
        hs = {b0.in_ready, b0.out_valid}; total_cnt++;
        if (hs !== 2'b10) $display("FAIL clear_in_hold got=%b exp=10", hs); else pass_cnt++;
        step();
        hs = {b0.in_ready, b0.out_valid}; total_cnt++;
        if (hs !== 2'b10) $display("FAIL clear_no_late_result got=%b exp=10", hs); else pass_cnt++;
        feed0(33'd2);
        feed0(33'd2);
        feed0(33'd2);
        feed0(33'd2);
        got = snap0(); exp = pk(0, 1, 0, 40'd8); total_cnt++;
        if (got !== exp) $display("FAIL clear_hold_then_block got=%h exp=%h", got, exp); else pass_cnt++;
        xfer0();
    endtask

    task automatic test_async_reset();
        feed0(33'd1);
        feed0(33'd2);
        #3;
        rst_n = 1'b0;
        #1;
        got = snap0(); exp = pk(0, 0, 0, 40'd0); total_cnt++;
        if (got !== exp) $display("FAIL async_reset_b0 got=%h exp=%h", got, exp); else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
        hs = {b0.in_ready, b0.out_valid}; total_cnt++;
        if (hs !== 2'b10) $display("FAIL async_reset_release got=%b exp=10", hs); else pass_cnt++;
        feed0(33'd1);
        feed0(33'd2);
        feed0(33'd3);
        feed0(33'd4);
        got = snap0(); exp = pk(0, 1, 0, 40'd10); total_cnt++;
        if (got !== exp) $display("FAIL async_reset_block got=%h exp=%h", got, exp); else pass_cnt++;
        xfer0();
    endtask

    task automatic test_count1();
        b2.sum_in = 33'd9; b2.in_valid = 1'b1;
        step();
        b2.in_valid = 1'b0;
        got = snap2(); exp = pk(0, 1, 0, 40'd9); total_cnt++;
        if (got !== exp) $display("FAIL count1_first got=%h exp=%h", got, exp); else pass_cnt++;
        b2.sum_in = 33'd3; b2.in_valid = 1'b1; b2.out_ready = 1'b1;
        step();
        b2.out_ready = 1'b0;
        hs = {b2.in_ready, b2.out_valid}; total_cnt++;
        if (hs !== 2'b10) $display("FAIL count1_no_bypass got=%b exp=10", hs); else pass_cnt++;
        step();
        b2.in_valid = 1'b0;
        got = snap2(); exp = pk(0, 1, 0, 40'd3); total_cnt++;
        if (got !== exp) $display("FAIL count1_second got=%h exp=%h", got, exp); else pass_cnt++;
        b2.out_ready = 1'b1;
        step();
        b2.out_ready = 1'b0;
        hs = {b2.in_ready, b2.out_valid}; total_cnt++;
        if (hs !== 2'b10) $display("FAIL count1_after_xfer got=%b exp=10", hs); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_count1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sum_block_accumulator.md
Name: sum_block_accumulator

Overview:
- Downstream consumer of the 33-bit combinational adder result.
- Accepts a stream of adder sums over a valid/ready handshake and accumulates COUNT consecutive sums into a wide accumulator.
- Presents each block total on an output valid/ready handshake, with a sticky overflow flag.
- Registers the adder output into the clocked datapath; one instance per adder.

Parameters:
- IN_W, 33, input sum width; matches adder output width.
- ACC_W, 40, accumulator width; must be >= IN_W.
- COUNT, 4, sums per block; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sum_in  input  IN_W  adder sum, zero-extended into the accumulator.
- in_valid  input  1  sum_in valid.
- in_ready  output  1  block can accept sum_in this cycle.
- clear  input  1  synchronous abort of the current block.
- acc_out  output  ACC_W  block total; valid only while out_valid=1.
- acc_ovf  output  1  carry out of ACC_W occurred during this block.
- out_valid  output  1  acc_out/acc_ovf valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (all registered outputs): in_ready=0, out_valid=0, acc_out=0, acc_ovf=0; state=IDLE; sample count=0.
- States: IDLE, ACCUM, HOLD.
- IDLE: entered on reset. Moves to ACCUM on the first clock after rst_n is released. in_ready rises to 1 with that transition.
- ACCUM: in_ready=1.
  - Accept = in_valid & in_ready.
  - On accept: acc <= acc + zero_ext(sum_in), computed modulo 2^ACC_W. If the add carries out of bit ACC_W-1, acc_ovf <= 1 (sticky within the block). Count increments.
  - When the accept is the COUNT-th of the block: next cycle state=HOLD, out_valid=1, in_ready=0, and acc_out holds the final total.
  - Latency: out_valid is asserted 1 cycle after the last accept.
  - COUNT=1: every accept goes straight to HOLD.
- HOLD: in_ready=0 and in_valid is ignored; upstream holds its data.
  - acc_out and acc_ovf stay stable until the output transfer.
  - Transfer = out_valid & out_ready. On transfer: next cycle out_valid=0, acc=0, acc_ovf=0, count=0, state=ACCUM, in_ready=1.
  - No accept is possible in the same cycle as a transfer (no bypass). Throughput is COUNT+1 cycles per block minimum.
- clear (synchronous, highest priority among sync events): next cycle acc=0, acc_ovf=0, count=0, out_valid=0, state=ACCUM, in_ready=1.
  - Any sum offered in the clear cycle is discarded, even if in_valid=1 and in_ready=1.
  - A result pending in HOLD is dropped, even if out_ready=1 in the same cycle.
  - clear while in IDLE: goes to ACCUM as normal.
- rst_n asserted mid-block or mid-HOLD: all state returns to reset values immediately (asynchronous); partial totals are lost.
- Width rules: sum_in is zero-extended. No saturation: the total wraps, and acc_ovf is the only indication of overflow.
- Outputs are register-driven; no combinational path from in_valid/out_ready to any output.

Test Plan:
- Basic block: defaults; after reset release, offer 1,2,3,4 back-to-back -> in_ready=1 from the 1st cycle after release; out_valid=1 one cycle after the 4th accept; acc_out=10, acc_ovf=0; out_ready=1 -> in_ready=1 the next cycle.
- Max input and overflow:
  - Defaults: four sums of 0x1_FFFF_FFFF -> acc_out=0x07_FFFF_FFFC, acc_ovf=0.
  - ACC_W=34, same inputs -> acc_out=0x3_FFFF_FFFC, acc_ovf=1.
  - Next block 1,1,1,1 -> acc_out=4, acc_ovf=0.
- Backpressure and gaps:
  - Random in_valid gaps -> only handshaked sums counted.
  - In HOLD, out_ready=0 for 5 cycles with in_valid=1 and sum_in=7 -> acc_out stable, in_ready=0, the 7 is not absorbed until the transfer.
- clear:
  - clear asserted after 2 of 4 accepts (5,6) -> next block 1,2,3,4 gives acc_out=10.
  - clear in HOLD with out_ready=1 -> no result delivered; out_valid=0 the next cycle.
- Async reset: drop rst_n mid-ACCUM between clock edges -> in_ready, out_valid, acc_out and acc_ovf go to 0 without waiting for a clock edge; after release, 1,2,3,4 gives 10.
- COUNT=1: offer 9, then 3 -> two results, 9 then 3, each 1 cycle after its accept; in_ready low during each HOLD.
